// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared definitions for the interrupt controller.
//   - default source count and acknowledge timeout
//   - counter width for the wait and timeout counters
//   - vector width helper and the controller state enum
package int_ctrl_pkg;

  localparam int N_SRC_DEF       = 4;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int CNT_W           = 8;

  // A single-source build still needs a 1-bit vector port.
  function automatic int vec_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VEC_W_DEF = vec_width(N_SRC_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bundle between the interrupt controller and the processor side.
//   irq_in      external interrupt lines (async, rising-edge triggered)
//   mask_we     mask register write strobe
//   mask_wdata  new mask value, 1 = source masked
//   int_ack     processor has taken the interrupt
//   int_done    processor retired its return-from-interrupt
//   interrupt   registered interrupt request
//   int_vec     index of the source being requested or serviced
//   busy        controller is in REQ or SERVICE
//   pending     pending-event register
//   timeout_cnt saturating count of abandoned requests
// slave modport is the controller, master modport the processor/stimulus side.
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int VEC_W = vec_width(N_SRC)
) ();

  logic [N_SRC-1:0] irq_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic             int_ack;
  logic             int_done;
  logic             interrupt;
  logic [VEC_W-1:0] int_vec;
  logic             busy;
  logic [N_SRC-1:0] pending;
  logic [CNT_W-1:0] timeout_cnt;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, int_done,
    input  interrupt, int_vec, busy, pending, timeout_cnt
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, int_done,
    output interrupt, int_vec, busy, pending, timeout_cnt
  );

endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: one interrupt line through a 2-flop synchronizer plus a
// previous-value flop; rise pulses for one cycle on a synchronized 0->1.
//   clk, rst  clock and async active-low reset
//   arm       enables edge reporting once the chain holds post-reset samples
//   irq       raw asynchronous interrupt line
//   rise      single-cycle rising-edge indication
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic irq,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = arm & sync2 & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: single-level interrupt controller with lowest-index priority,
// per-source mask, acknowledge timeout and a saturating timeout counter.
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   int_ctrl_if.slave (irq lines, mask write, ack/done handshake,
//         interrupt/int_vec/busy/pending/timeout_cnt status)
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for an unmasked pending source
// REQ     | interrupt asserted, waiting up to ACK_TIMEOUT for int_ack
// SERVICE | handler running, waiting for int_done
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst,
  int_ctrl_if.slave  bus
);

  localparam int               VEC_W     = vec_width(N_SRC);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req;
  logic [VEC_W-1:0] low_idx;
  logic [1:0]       prime_q;
  logic             arm;

  // A line already high when reset releases would otherwise look like a
  // fresh edge once sync2 fills while prev is still 0. Edge reporting is
  // held off until prev carries a post-reset sample.
  assign arm = (prime_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q <= 2'd0;
    end else if (prime_q != 2'd3) begin
      prime_q <= prime_q + 2'd1;
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .arm  (arm),
      .irq  (bus.irq_in[i]),
      .rise (rise[i])
    );
  end

  assign req = pending_q & ~mask_q;

  always_comb begin
    low_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) low_idx = VEC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      wait_q    <= '0;
      tcnt_q    <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      wait_q    <= wait_d;
      tcnt_q    <= tcnt_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    tcnt_d  = tcnt_q;
    clr     = '0;
    mask_d  = bus.mask_we ? bus.mask_wdata : mask_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          vec_d   = low_idx;
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acknowledge beats a timeout landing in the same cycle.
        if (bus.int_ack) begin
          clr     = N_SRC'(1) << vec_q;
          state_d = ST_SERVICE;
        end else if (wait_q == WAIT_LAST) begin
          if (tcnt_q != CNT_MAX) tcnt_d = tcnt_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.int_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge on the bit being acknowledged survives the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  assign bus.interrupt   = (state_q == ST_REQ);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.int_vec     = vec_q;
  assign bus.pending     = pending_q;
  assign bus.timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  int_ctrl_if #(.N_SRC(4)) bus ();

  int_ctrl #(.N_SRC(4), .ACK_TIMEOUT(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.int_ack    = 1'b0;
    bus.int_done   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  task automatic wait_int(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.interrupt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_vec(input string name);
    logic [1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: int_vec %0d observed with empty scoreboard", name, bus.int_vec);
    end else begin
      e = exp_q.pop_front();
      if (bus.int_vec !== e) begin
        errors++;
        $display("FAIL %s: int_vec got %0d want %0d", name, bus.int_vec, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.irq_in = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL rst_interrupt: got %b want 0", bus.interrupt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b want 0000", bus.pending); end
    checks++; if (bus.int_vec !== 2'd0) begin errors++; $display("FAIL rst_vec: got %0d want 0", bus.int_vec); end
    checks++; if (bus.timeout_cnt !== 8'd0) begin errors++; $display("FAIL rst_tcnt: got %0d want 0", bus.timeout_cnt); end
    rst = 1'b1;
    repeat (6) tick();
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL rst_edge_dropped: pending got %b want 0000", bus.pending); end
    bus.irq_in = 4'b1001;
    repeat (5) tick();
    checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL rst_masked_pending: got %b want 1000", bus.pending); end
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL rst_mask_ones: interrupt got %b want 0", bus.interrupt); end
  endtask

  task automatic test_single();
    do_reset();
    set_mask(4'b0000);
    bus.irq_in[2] = 1'b1;
    exp_q.push_back(2'd2);
    repeat (3) tick();
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL single_pending_e3: got %b want 0100", bus.pending); end
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL single_int_e3: got %b want 0", bus.interrupt); end
    tick();
    checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL single_int_e4: got %b want 1", bus.interrupt); end
    pop_vec("single_vec");
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_service: int %b busy %b want 0 1", bus.interrupt, bus.busy); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL single_cleared: got %b want 0000", bus.pending); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.int_vec !== 2'd2) begin errors++; $display("FAIL single_ack_ignored: busy %b vec %0d want 1 2", bus.busy, bus.int_vec); end
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_priority();
    bit seen;
    do_reset();
    set_mask(4'b0000);
    bus.irq_in = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    wait_int(8, seen);
    checks++; if (!seen) begin errors++; $display("FAIL prio_first_req: interrupt got 0 want 1 within 8 cycles"); end
    pop_vec("prio_first_vec");
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL prio_pending: got %b want 1000", bus.pending); end
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
    wait_int(8, seen);
    checks++; if (!seen) begin errors++; $display("FAIL prio_second_req: interrupt got 0 want 1 within 8 cycles"); end
    pop_vec("prio_second_vec");
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
    checks++; if (bus.pending !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL prio_end: pending %b busy %b want 0000 0", bus.pending, bus.busy); end
  endtask

  task automatic test_mask();
    do_reset();
    set_mask(4'b0010);
    bus.irq_in[1] = 1'b1;
    repeat (5) tick();
    checks++; if (bus.pending !== 4'b0010) begin errors++; $display("FAIL mask_pending: got %b want 0010", bus.pending); end
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL mask_gated: interrupt got %b want 0", bus.interrupt); end
    exp_q.push_back(2'd1);
    set_mask(4'b0000);
    checks++; if (bus.interrupt !== 1'b0) begin errors++; $display("FAIL mask_write_edge: interrupt got %b want 0", bus.interrupt); end
    tick();
    checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL mask_unmask_req: interrupt got %b want 1", bus.interrupt); end
    pop_vec("mask_vec");
    set_mask(4'b1111);
    checks++; if (bus.interrupt !== 1'b1) begin errors++; $display("FAIL mask_no_cancel: interrupt got %b want 1", bus.interrupt); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  task automatic test_timeout();
    bit seen;
    int hi;
    do_reset();
    set_mask(4'b0000);
    bus.irq_in[0] = 1'b1;
    exp_q.push_back(2'd0);
    wait_int(8, seen);
    checks++; if (!seen) begin errors++; $display("FAIL to_req: interrupt got 0 want 1 within 8 cycles"); end
    pop_vec("to_vec");
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.interrupt === 1'b1) hi++;
      else break;
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL to_high_cycles: got %0d want 5", hi); end
    checks++; if (bus.timeout_cnt !== 8'd1) begin errors++; $display("FAIL to_count: got %0d want 1", bus.timeout_cnt); end
    checks++; if (bus.pending !== 4'b0001 || bus.busy !== 1'b0) begin errors++; $display("FAIL to_kept: pending %b busy %b want 0001 0", bus.pending, bus.busy); end
    exp_q.push_back(2'd0);
    wait_int(4, seen);
    checks++; if (!seen) begin errors++; $display("FAIL to_reissue: interrupt got 0 want 1 within 4 cycles"); end
    pop_vec("to_reissue_vec");
    repeat (1600) tick();
    checks++; if (bus.timeout_cnt !== 8'd255) begin errors++; $display("FAIL to_saturate: got %0d want 255", bus.timeout_cnt); end
    wait_int(8, seen);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
    checks++; if (bus.pending !== 4'b0000 || bus.timeout_cnt !== 8'd255) begin errors++; $display("FAIL to_final: pending %b tcnt %0d want 0000 255", bus.pending, bus.timeout_cnt); end
  endtask

  task automatic test_reset_active();
    bit seen;
    do_reset();
    set_mask(4'b0000);
    bus.irq_in[1] = 1'b1;
    exp_q.push_back(2'd1);
    wait_int(8, seen);
    pop_vec("arst_req_vec");
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_req: int %b busy %b want 0 0", bus.interrupt, bus.busy); end
    bus.irq_in = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) tick();
    set_mask(4'b0000);
    bus.irq_in[1] = 1'b1;
    exp_q.push_back(2'd1);
    wait_int(8, seen);
    pop_vec("arst_svc_vec");
    bus.irq_in[3] = 1'b1;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b1 || bus.pending !== 4'b1000) begin errors++; $display("FAIL arst_pre: busy %b pending %b want 1 1000", bus.busy, bus.pending); end
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.interrupt !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_svc: int %b busy %b want 0 0", bus.interrupt, bus.busy); end
    checks++; if (bus.pending !== 4'b0000 || bus.int_vec !== 2'd0) begin errors++; $display("FAIL arst_clear: pending %b vec %0d want 0000 0", bus.pending, bus.int_vec); end
    bus.irq_in = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) tick();
    bus.irq_in[2] = 1'b1;
    repeat (5) tick();
    checks++; if (bus.pending !== 4'b0100 || bus.interrupt !== 1'b0) begin errors++; $display("FAIL arst_mask: pending %b int %b want 0100 0", bus.pending, bus.interrupt); end
  endtask

  task automatic test_set_wins();
    bit seen;
    do_reset();
    set_mask(4'b0000);
    bus.irq_in[0] = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    bus.irq_in[0] = 1'b0;
    wait_int(8, seen);
    checks++; if (!seen) begin errors++; $display("FAIL setwin_req: interrupt got 0 want 1 within 8 cycles"); end
    pop_vec("setwin_vec");
    bus.irq_in[0] = 1'b1;
    repeat (2) tick();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    checks++; if (bus.pending[0] !== 1'b1 || bus.busy !== 1'b1 || bus.interrupt !== 1'b0) begin errors++; $display("FAIL setwin_pending: pending %b busy %b int %b want xxx1 1 0", bus.pending, bus.busy, bus.interrupt); end
    exp_q.push_back(2'd0);
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
    wait_int(4, seen);
    checks++; if (!seen) begin errors++; $display("FAIL setwin_second: interrupt got 0 want 1 within 4 cycles"); end
    pop_vec("setwin_second_vec");
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_timeout();
    test_reset_active();
    test_set_wins();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
